// File: rtl/sub_sat_pkg.sv
// Shared definitions for the saturating subtractor output stage: clamp limits and
// skid-buffer state encoding.
package sub_sat_pkg;

  localparam int SAT_CALC_W = 64;

  // Largest positive two's-complement value of width w, right-aligned in SAT_CALC_W bits.
  function automatic logic [SAT_CALC_W-1:0] sat_max(input int w);
    return (SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1);
  endfunction

  // Most negative two's-complement value of width w (only the sign bit set).
  function automatic logic [SAT_CALC_W-1:0] sat_min(input int w);
    return SAT_CALC_W'(1) << (w - 1);
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/sub_sat_skid.sv
// Generic 2-entry skid buffer: head register drives the output, skid register absorbs
// one word of backpressure so in_ready can be registered.
module sub_sat_skid
  import sub_sat_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_word,
  output logic out_valid,
  input  logic out_ready,
  output T     out_word
);

  skid_state_t state_q;
  T            head_q;
  T            skid_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        push;
  logic        pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = head_q;

  // NOTE: skid_q has no reset; it is only ever read after being loaded in ONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_q      <= in_word;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= in_word;
          end else if (push) begin
            skid_q     <= in_word;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sub_sat_pipe.sv
// Saturating output stage of the signed subtractor with sticky overflow flag.
// Define SUB_SAT_OVF_CNT_EN to build the saturating overflow event counter.
module sub_sat_pipe
  import sub_sat_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_diff,
  input  logic             in_ovf,
  input  logic             in_a_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             ovf_sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sat;
  } word_t;

  localparam logic [WIDTH-1:0] SAT_MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN_V = WIDTH'(sat_min(WIDTH));

  word_t in_word;
  word_t out_word;
  logic  accept_ovf;
  logic  sticky_d;
  logic  sticky_q;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    in_word = '{data: in_diff, sat: 1'b0};
    if (in_ovf) begin
      // The wrapped difference is meaningless on overflow; A's sign picks the clamp rail.
      in_word = '{data: (in_a_msb ? SAT_MIN_V : SAT_MAX_V), sat: 1'b1};
    end
  end

  sub_sat_skid #(
    .T(word_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word)
  );

  assign out_data   = out_word.data;
  assign out_sat    = out_word.sat;
  assign accept_ovf = in_valid & in_ready & in_ovf;

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (accept_ovf) sticky_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;

`ifdef SUB_SAT_OVF_CNT_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sticky_clr) cnt_d = '0;
    // A same-cycle clear restarts the count at this overflow.
    if (accept_ovf && (sticky_clr || (cnt_q != '1))) cnt_d = cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule
